vote_tally_unit: RTL and testbench

Sequential front end of the voting machine. It arms one ballot per officer authorisation, captures exactly one candidate button press per ballot, and keeps saturating per-candidate vote counters. It also closes the poll. Its candidate-number and vote-count outputs drive the combinational winner-selection stage directly. `result_valid` tells that stage when the counts are final.

---
 rtl/evm_pkg.sv | 23 ++
 rtl/vote_counter_sat.sv | 26 ++
 rtl/vote_tally_unit.sv | 129 ++++++++++++
 tb/tb_vote_tally_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared definitions for the voting machine front end: FSM states, default
// counter width and the numbers presented for each candidate.
package evm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_CLOSED = 2'd3
  } state_t;

  localparam int          NUM_CAND      = 3;
  localparam int          CNT_W_DEF     = 4;
  localparam logic [3:0]  CAND_ID_0_DEF = 4'd1;
  localparam logic [3:0]  CAND_ID_1_DEF = 4'd2;
  localparam logic [3:0]  CAND_ID_2_DEF = 4'd3;

  // True when exactly one bit of a candidate button vector is set.
  function automatic logic is_onehot(input logic [NUM_CAND-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/vote_counter_sat.sv
// Unsigned vote counter that sticks at its maximum; sat_hit flags an
// increment request that arrived while the counter was already full.
module vote_counter_sat #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat_hit
);

  logic full;

  assign full    = &count;
  assign sat_hit = inc & full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !full) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vote_tally_unit.sv
// Ballot sequencing front end: arms one ballot per authorisation, accepts a
// single clean button press per ballot, and tallies votes until the poll closes.
module vote_tally_unit
  import evm_pkg::*;
#(
  parameter int         CNT_W     = CNT_W_DEF,
  parameter logic [3:0] CAND_ID_0 = CAND_ID_0_DEF,
  parameter logic [3:0] CAND_ID_1 = CAND_ID_1_DEF,
  parameter logic [3:0] CAND_ID_2 = CAND_ID_2_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ballot_en,
  input  logic [2:0]       vote_btn,
  input  logic             close_poll,
  output logic [3:0]       candidate_number_0,
  output logic [3:0]       candidate_number_1,
  output logic [3:0]       candidate_number_2,
  output logic [CNT_W-1:0] vote_count_0,
  output logic [CNT_W-1:0] vote_count_1,
  output logic [CNT_W-1:0] vote_count_2,
  output logic             ballot_ready,
  output logic             vote_ack,
  output logic             invalid_press,
  output logic             sat_err,
  output logic             result_valid,
  output logic [1:0]       state_dbg
);

  // Handshake: ballot_ready is the "ready" side of a ballot; a press edge
  // is the "valid" side and is consumed only on a cycle where ballot_ready
  // is high, answered by vote_ack (accepted) or invalid_press (rejected).

  state_t              state, state_n;
  logic [NUM_CAND-1:0] btn_q;
  logic [NUM_CAND-1:0] press;
  logic                valid_press;
  logic [NUM_CAND-1:0] inc_vec;
  logic [NUM_CAND-1:0] sat_hit_vec;
  logic                ack_d;
  logic                inv_d;
  logic [CNT_W-1:0]    count_arr [NUM_CAND];

  assign candidate_number_0 = CAND_ID_0;
  assign candidate_number_1 = CAND_ID_1;
  assign candidate_number_2 = CAND_ID_2;

  // A press counts only if it starts from all buttons released.
  assign press       = vote_btn & ~btn_q;
  assign valid_press = (btn_q == '0) && is_onehot(press);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      btn_q <= '0;
    end else begin
      state <= state_n;
      btn_q <= vote_btn;
    end
  end

  always_comb begin
    state_n = state;
    ack_d   = 1'b0;
    inv_d   = 1'b0;
    inc_vec = '0;
    case (state)
      ST_IDLE: begin
        if (close_poll)     state_n = ST_CLOSED;
        else if (ballot_en) state_n = ST_ARMED;
      end
      ST_ARMED: begin
        // Closing wins over a press arriving in the same cycle.
        if (close_poll) begin
          state_n = ST_CLOSED;
        end else if (valid_press) begin
          inc_vec = press;
          ack_d   = 1'b1;
          state_n = ST_HOLD;
        end else if (press != '0) begin
          inv_d   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (close_poll)            state_n = ST_CLOSED;
        else if (vote_btn == '0)   state_n = ST_IDLE;
      end
      ST_CLOSED: begin
        state_n = ST_CLOSED;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_ack      <= 1'b0;
      invalid_press <= 1'b0;
      sat_err       <= 1'b0;
    end else begin
      vote_ack      <= ack_d;
      invalid_press <= inv_d;
      sat_err       <= sat_err | (|sat_hit_vec);
    end
  end

  for (genvar i = 0; i < NUM_CAND; i++) begin : g_cnt
    vote_counter_sat #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc_vec[i]),
      .count   (count_arr[i]),
      .sat_hit (sat_hit_vec[i])
    );
  end

  assign vote_count_0 = count_arr[0];
  assign vote_count_1 = count_arr[1];
  assign vote_count_2 = count_arr[2];

  assign ballot_ready = (state == ST_ARMED);
  assign result_valid = (state == ST_CLOSED);
  assign state_dbg    = state;

endmodule

// File: tb/tb_vote_tally_unit.sv
// Directed bench for vote_tally_unit: a vector table for the single-cycle
// behaviour plus hand-written sequences for saturation and async reset.
module tb_vote_tally_unit;
  import evm_pkg::*;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_A = 2'd1;
  localparam logic [1:0] S_H = 2'd2;
  localparam logic [1:0] S_C = 2'd3;

  logic       clk;
  logic       rst_n;
  logic       ballot_en;
  logic [2:0] vote_btn;
  logic       close_poll;
  logic [3:0] candidate_number_0, candidate_number_1, candidate_number_2;
  logic [3:0] vote_count_0, vote_count_1, vote_count_2;
  logic       ballot_ready, vote_ack, invalid_press, sat_err, result_valid;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       be;
    logic [2:0] btn;
    logic       cp;
    logic [1:0] st;
    logic       ack;
    logic       inv;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [3:0] c2;
  } vec_t;

  vec_t vecs[$];

  vote_tally_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ballot_en          (ballot_en),
    .vote_btn           (vote_btn),
    .close_poll         (close_poll),
    .candidate_number_0 (candidate_number_0),
    .candidate_number_1 (candidate_number_1),
    .candidate_number_2 (candidate_number_2),
    .vote_count_0       (vote_count_0),
    .vote_count_1       (vote_count_1),
    .vote_count_2       (vote_count_2),
    .ballot_ready       (ballot_ready),
    .vote_ack           (vote_ack),
    .invalid_press      (invalid_press),
    .sat_err            (sat_err),
    .result_valid       (result_valid),
    .state_dbg          (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drivers: inputs change on the falling edge, outputs sampled 1ns after rise.
  task automatic step(input logic be, input logic [2:0] btn, input logic cp);
    @(negedge clk);
    ballot_en  = be;
    vote_btn   = btn;
    close_poll = cp;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    ballot_en  = 1'b0;
    vote_btn   = 3'b000;
    close_poll = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete 3-cycle ballot; returns whether vote_ack was seen.
  task automatic ballot(input logic [2:0] btn, output logic acked);
    step(1'b1, 3'b000, 1'b0);
    step(1'b0, btn, 1'b0);
    acked = vote_ack;
    step(1'b0, 3'b000, 1'b0);
  endtask

  task automatic add(input logic be, input logic [2:0] btn, input logic cp,
                     input logic [1:0] st, input logic ack, input logic inv,
                     input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2);
    vec_t v;
    v.be = be; v.btn = btn; v.cp = cp; v.st = st; v.ack = ack; v.inv = inv;
    v.c0 = c0; v.c1 = c1; v.c2 = c2;
    vecs.push_back(v);
  endtask

  initial begin
    logic acked;
    int   acks;

    rst_n = 1'b0; ballot_en = 1'b0; vote_btn = 3'b000; close_poll = 1'b0;

    //   be  btn    cp  state ack inv c0 c1 c2
    add(1, 3'b000, 0, S_A, 0, 0, 0, 0, 0); // authorise
    add(0, 3'b010, 0, S_H, 1, 0, 0, 1, 0); // vote cand 1
    add(0, 3'b010, 0, S_H, 0, 0, 0, 1, 0); // still held
    add(0, 3'b000, 0, S_I, 0, 0, 0, 1, 0); // release
    add(0, 3'b001, 0, S_I, 0, 0, 0, 1, 0); // press in IDLE ignored
    add(0, 3'b000, 0, S_I, 0, 0, 0, 1, 0);
    add(1, 3'b000, 0, S_A, 0, 0, 0, 1, 0);
    add(0, 3'b001, 0, S_H, 1, 0, 1, 1, 0); // vote cand 0
    add(0, 3'b000, 0, S_I, 0, 0, 1, 1, 0);
    add(0, 3'b001, 0, S_I, 0, 0, 1, 1, 0); // second press, no ballot
    add(0, 3'b000, 0, S_I, 0, 0, 1, 1, 0);
    add(1, 3'b000, 0, S_A, 0, 0, 1, 1, 0);
    add(0, 3'b101, 0, S_A, 0, 1, 1, 1, 0); // two-button edge rejected
    add(0, 3'b100, 0, S_A, 0, 0, 1, 1, 0); // partial release, no edge
    add(0, 3'b000, 0, S_A, 0, 0, 1, 1, 0);
    add(0, 3'b100, 0, S_H, 1, 0, 1, 1, 1); // clean press cand 2
    add(0, 3'b000, 0, S_I, 0, 0, 1, 1, 1);
    add(1, 3'b001, 0, S_A, 0, 0, 1, 1, 1); // enter ARMED with button held
    add(0, 3'b001, 0, S_A, 0, 0, 1, 1, 1); // held: no edge
    add(0, 3'b101, 0, S_A, 0, 1, 1, 1, 1); // edge while another held
    add(0, 3'b000, 0, S_A, 0, 0, 1, 1, 1);
    add(0, 3'b010, 0, S_H, 1, 0, 1, 2, 1);
    add(1, 3'b010, 0, S_H, 0, 0, 1, 2, 1); // ballot_en ignored in HOLD
    add(1, 3'b000, 0, S_I, 0, 0, 1, 2, 1);
    add(1, 3'b000, 0, S_A, 0, 0, 1, 2, 1); // held ballot_en re-arms from IDLE
    add(0, 3'b100, 1, S_C, 0, 0, 1, 2, 1); // close beats press
    add(1, 3'b000, 0, S_C, 0, 0, 1, 2, 1);
    add(1, 3'b001, 0, S_C, 0, 0, 1, 2, 1); // inputs ignored once closed
    add(0, 3'b000, 0, S_C, 0, 0, 1, 2, 1);

    // Reset state, including constants visible during reset
    #12;
    chk("rst_cand0", candidate_number_0, 4'd1);
    chk("rst_cand1", candidate_number_1, 4'd2);
    chk("rst_cand2", candidate_number_2, 4'd3);
    chk("rst_counts", {vote_count_0, vote_count_1, vote_count_2}, 12'h000);
    chk("rst_flags", {ballot_ready, vote_ack, invalid_press, sat_err, result_valid}, 5'b0);
    chk("rst_state", state_dbg, S_I);
    do_reset();

    foreach (vecs[i]) begin
      step(vecs[i].be, vecs[i].btn, vecs[i].cp);
      chk($sformatf("v%0d_state", i), state_dbg, vecs[i].st);
      chk($sformatf("v%0d_ready", i), ballot_ready, vecs[i].st == S_A);
      chk($sformatf("v%0d_rvalid", i), result_valid, vecs[i].st == S_C);
      chk($sformatf("v%0d_ack", i), vote_ack, vecs[i].ack);
      chk($sformatf("v%0d_inv", i), invalid_press, vecs[i].inv);
      chk($sformatf("v%0d_c0", i), vote_count_0, vecs[i].c0);
      chk($sformatf("v%0d_c1", i), vote_count_1, vecs[i].c1);
      chk($sformatf("v%0d_c2", i), vote_count_2, vecs[i].c2);
      chk($sformatf("v%0d_sat", i), sat_err, 1'b0);
    end

    // Saturation: 16 ballots for candidate 0
    do_reset();
    acks = 0;
    for (int n = 1; n <= 16; n++) begin
      ballot(3'b001, acked);
      if (acked) acks++;
      if (n == 15) begin
        chk("sat_c0_at15", vote_count_0, 4'd15);
        chk("sat_err_at15", sat_err, 1'b0);
      end
    end
    chk("sat_c0_final", vote_count_0, 4'd15);
    chk("sat_err_final", sat_err, 1'b1);
    chk("sat_ack_count", acks, 16);
    chk("sat_others", {vote_count_1, vote_count_2}, 8'h00);
    ballot(3'b010, acked);
    chk("sat_err_sticky", sat_err, 1'b1);
    chk("sat_c1_after", vote_count_1, 4'd1);

    // Close from HOLD keeps the vote just cast
    do_reset();
    step(1'b1, 3'b000, 1'b0);
    step(1'b0, 3'b100, 1'b0);
    step(1'b0, 3'b100, 1'b1);
    chk("hold_close_state", state_dbg, S_C);
    chk("hold_close_rvalid", result_valid, 1'b1);
    chk("hold_close_c2", vote_count_2, 4'd1);

    // Async reset mid-HOLD with counts 3/2/1
    do_reset();
    for (int n = 0; n < 3; n++) ballot(3'b001, acked);
    for (int n = 0; n < 2; n++) ballot(3'b010, acked);
    step(1'b1, 3'b000, 1'b0);
    step(1'b0, 3'b100, 1'b0);
    chk("pre_rst_state", state_dbg, S_H);
    chk("pre_rst_counts", {vote_count_0, vote_count_1, vote_count_2}, 12'h321);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_counts", {vote_count_0, vote_count_1, vote_count_2}, 12'h000);
    chk("arst_state", state_dbg, S_I);
    chk("arst_rvalid", result_valid, 1'b0);
    chk("arst_cand", {candidate_number_0, candidate_number_1, candidate_number_2}, 12'h123);

    // Async reset out of CLOSED drops result_valid without a clock edge
    do_reset();
    step(1'b0, 3'b000, 1'b1);
    chk("closed_rvalid", result_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_closed_rvalid", result_valid, 1'b0);
    chk("arst_closed_state", state_dbg, S_I);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
